kronos_branch_pipe: RTL and testbench

//  Pipelined, width-parametrised branch resolution unit; successor to the combinational branch comparator.

---
 rtl/kronos_branch_pipe.sv | 143 ++++++++++++++
 tb/tb_kronos_branch_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_branch_pipe.sv
// Two-stage pipelined branch resolution unit with valid/ready handshakes and flush.
// Optional branch target adder is enabled by defining KRONOS_BRANCH_TARGET_EN.
module kronos_branch_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             out_branch,
  output logic             out_illegal,
  output logic [WIDTH-1:0] out_target,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic       adv1_s, adv2_s;
  logic       s1_vld_q, s1_vld_d;
  logic [2:0] s1_op_q;
  logic       s1_eq_lo_q, s1_eq_lo_d;
  logic       s1_ltu_lo_q, s1_ltu_lo_d;
  logic       s1_eq_hi_q, s1_eq_hi_d;
  logic       s1_lt_hi_q, s1_lt_hi_d;
  logic       s2_vld_q;
  logic       s2_branch_q, s2_branch_d;
  logic       s2_illegal_q, s2_illegal_d;
  logic       eq_s, lt_s;

  assign adv2_s = !s2_vld_q | out_rdy;
  assign adv1_s = !s1_vld_q | adv2_s;
  assign in_rdy = adv1_s & !flush;

  // Stage-1 partial compares: low half always unsigned, high half carries the sign for BLT/BGE.
  always_comb begin
    s1_vld_d    = in_vld & in_rdy;
    s1_eq_lo_d  = (in_rs1[SPLIT-1:0] == in_rs2[SPLIT-1:0]);
    s1_ltu_lo_d = (in_rs1[SPLIT-1:0] <  in_rs2[SPLIT-1:0]);
    s1_eq_hi_d  = (in_rs1[WIDTH-1:SPLIT] == in_rs2[WIDTH-1:SPLIT]);
    if (in_op[1]) begin
      s1_lt_hi_d = (in_rs1[WIDTH-1:SPLIT] < in_rs2[WIDTH-1:SPLIT]);
    end else begin
      s1_lt_hi_d = ($signed(in_rs1[WIDTH-1:SPLIT]) < $signed(in_rs2[WIDTH-1:SPLIT]));
    end
  end

  // Stage-2 merge of the half compares into the final branch decision.
  always_comb begin
    eq_s         = s1_eq_hi_q & s1_eq_lo_q;
    lt_s         = s1_lt_hi_q | (s1_eq_hi_q & s1_ltu_lo_q);
    s2_illegal_d = (s1_op_q[2:1] == 2'b01);
    if (s2_illegal_d) begin
      s2_branch_d = 1'b0;
    end else if (s1_op_q[2]) begin
      s2_branch_d = lt_s ^ s1_op_q[0];
    end else begin
      s2_branch_d = eq_s ^ s1_op_q[0];
    end
  end

  // Stage-1 registers; a flush empties the stage even when it is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_op_q     <= 3'b000;
      s1_eq_lo_q  <= 1'b0;
      s1_ltu_lo_q <= 1'b0;
      s1_eq_hi_q  <= 1'b0;
      s1_lt_hi_q  <= 1'b0;
    end else begin
      if (flush) begin
        s1_vld_q <= 1'b0;
      end else if (adv1_s) begin
        s1_vld_q <= s1_vld_d;
      end
      if (adv1_s) begin
        s1_op_q     <= in_op;
        s1_eq_lo_q  <= s1_eq_lo_d;
        s1_ltu_lo_q <= s1_ltu_lo_d;
        s1_eq_hi_q  <= s1_eq_hi_d;
        s1_lt_hi_q  <= s1_lt_hi_d;
      end
    end
  end

  // Stage-2 / output registers; data only moves on adv2 so a stalled result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q     <= 1'b0;
      s2_branch_q  <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        s2_vld_q <= 1'b0;
      end else if (adv2_s) begin
        s2_vld_q <= s1_vld_q;
      end
      if (adv2_s) begin
        s2_branch_q  <= s2_branch_d;
        s2_illegal_q <= s2_illegal_d;
      end
    end
  end

  assign out_vld     = s2_vld_q;
  assign out_branch  = s2_branch_q;
  assign out_illegal = s2_illegal_q;

`ifdef KRONOS_BRANCH_TARGET_EN
  logic [WIDTH-1:0] s1_tgt_q, s1_tgt_d;
  logic [WIDTH-1:0] s2_tgt_q;

  assign s1_tgt_d = in_pc + in_imm;

  // Target pipeline follows the same advance enables as the compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tgt_q <= {WIDTH{1'b0}};
      s2_tgt_q <= {WIDTH{1'b0}};
    end else begin
      if (adv1_s) begin
        s1_tgt_q <= s1_tgt_d;
      end
      if (adv2_s) begin
        s2_tgt_q <= s1_tgt_q;
      end
    end
  end

  assign out_target = s2_tgt_q;
`else
  logic unused_target_ops;
  assign unused_target_ops = ^{in_pc, in_imm};
  assign out_target        = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_kronos_branch_pipe.sv
// Self-checking bench: two instances (WIDTH=32/SPLIT=16 and WIDTH=8/SPLIT=1) share control
// signals and are checked against a queue-based reference of an in-order two-deep pipe.
module tb_kronos_branch_pipe;

  typedef struct {
    logic        br;
    logic        il;
    logic [31:0] tg;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_vld, out_rdy;
  logic [2:0]  in_op;
  logic [31:0] a_rs1, a_rs2, a_pc, a_imm, a_target;
  logic [7:0]  b_rs1, b_rs2, b_pc, b_imm, b_target;
  logic        a_in_rdy, a_branch, a_illegal, a_out_vld;
  logic        b_in_rdy, b_branch, b_illegal, b_out_vld;

  int checks = 0;
  int failures = 0;
  res_t q32[$];
  res_t q8[$];
  logic        stall_prev;
  logic        sv_a_br, sv_a_il, sv_b_br, sv_b_il;
  logic [31:0] sv_a_tg;
  logic [7:0]  sv_b_tg;
  logic [31:0] exp_tgt_dir;

  kronos_branch_pipe #(.WIDTH(32), .SPLIT(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_op(in_op), .in_rs1(a_rs1), .in_rs2(a_rs2),
    .in_pc(a_pc), .in_imm(a_imm), .in_vld(in_vld), .in_rdy(a_in_rdy), .out_branch(a_branch),
    .out_illegal(a_illegal), .out_target(a_target), .out_vld(a_out_vld), .out_rdy(out_rdy));

  kronos_branch_pipe #(.WIDTH(8), .SPLIT(1)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_op(in_op), .in_rs1(b_rs1), .in_rs2(b_rs2),
    .in_pc(b_pc), .in_imm(b_imm), .in_vld(in_vld), .in_rdy(b_in_rdy), .out_branch(b_branch),
    .out_illegal(b_illegal), .out_target(b_target), .out_vld(b_out_vld), .out_rdy(out_rdy));

  always #5 clk = ~clk;

  function automatic res_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] pc, input logic [31:0] imm, input int w);
    res_t r;
    longint m, half, ua, ub, sa, sb;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'h0, a}) & m;
    ub   = longint'({32'h0, b}) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    r.il = (op == 3'b010) || (op == 3'b011);
    case (op)
      3'b000:  r.br = (ua == ub);
      3'b001:  r.br = (ua != ub);
      3'b100:  r.br = (sa <  sb);
      3'b101:  r.br = (sa >= sb);
      3'b110:  r.br = (ua <  ub);
      3'b111:  r.br = (ua >= ub);
      default: r.br = 1'b0;
    endcase
`ifdef KRONOS_BRANCH_TARGET_EN
    r.tg = 32'((longint'({32'h0, pc}) + longint'({32'h0, imm})) & m);
`else
    r.tg = 32'h0;
`endif
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: in_rdy iff not flushing and fewer than two ops in flight (or the head leaves).
  task automatic eval();
    logic exp_rdy;
    if (rst) begin
      q32.delete();
      q8.delete();
      stall_prev = 1'b0;
      return;
    end
    exp_rdy = !flush && ((q32.size() < 2) || out_rdy);
    chk1("in_rdy32", a_in_rdy, exp_rdy);
    chk1("in_rdy8", b_in_rdy, exp_rdy);
    if (q32.size() == 0) chk1("vld_empty32", a_out_vld, 1'b0);
    if (q8.size() == 0)  chk1("vld_empty8", b_out_vld, 1'b0);
    if (q32.size() == 2) chk1("vld_full32", a_out_vld, 1'b1);
    if (q8.size() == 2)  chk1("vld_full8", b_out_vld, 1'b1);
    if (stall_prev) begin
      chk1("stall_vld32", a_out_vld, 1'b1);
      chk1("stall_br32", a_branch, sv_a_br);
      chk1("stall_il32", a_illegal, sv_a_il);
      chk32("stall_tg32", a_target, sv_a_tg);
      chk1("stall_br8", b_branch, sv_b_br);
      chk1("stall_il8", b_illegal, sv_b_il);
      chk32("stall_tg8", {24'h0, b_target}, {24'h0, sv_b_tg});
    end
    if (a_out_vld && q32.size() > 0) begin
      chk1("br32", a_branch, q32[0].br);
      chk1("il32", a_illegal, q32[0].il);
      chk32("tg32", a_target, q32[0].tg);
      if (out_rdy && !flush) void'(q32.pop_front());
    end
    if (b_out_vld && q8.size() > 0) begin
      chk1("br8", b_branch, q8[0].br);
      chk1("il8", b_illegal, q8[0].il);
      chk32("tg8", {24'h0, b_target}, q8[0].tg);
      if (out_rdy && !flush) void'(q8.pop_front());
    end
    if (in_vld && a_in_rdy) begin
      q32.push_back(ref_model(in_op, a_rs1, a_rs2, a_pc, a_imm, 32));
      q8.push_back(ref_model(in_op, {24'h0, b_rs1}, {24'h0, b_rs2}, {24'h0, b_pc}, {24'h0, b_imm}, 8));
    end
    if (flush) begin
      q32.delete();
      q8.delete();
    end
    stall_prev = a_out_vld && !out_rdy && !flush;
    sv_a_br = a_branch;
    sv_a_il = a_illegal;
    sv_a_tg = a_target;
    sv_b_br = b_branch;
    sv_b_il = b_illegal;
    sv_b_tg = b_target;
  endtask

  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] pc, input logic [31:0] imm, input logic [7:0] r1b,
                     input logic [7:0] r2b, input logic [7:0] pcb, input logic [7:0] immb,
                     input logic ordy, input logic fl);
    @(negedge clk);
    in_vld  = v;
    in_op   = op;
    a_rs1   = r1;
    a_rs2   = r2;
    a_pc    = pc;
    a_imm   = imm;
    b_rs1   = r1b;
    b_rs2   = r2b;
    b_pc    = pcb;
    b_imm   = immb;
    out_rdy = ordy;
    flush   = fl;
    #1;
    eval();
  endtask

  task automatic dcyc(input logic v, input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] pc, input logic [31:0] imm, input logic ordy, input logic fl);
    cyc(v, op, r1, r2, pc, imm, r1[7:0], r2[7:0], pc[7:0], imm[7:0], ordy, fl);
  endtask

  task automatic idle(input logic ordy);
    dcyc(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic exp_br, input logic exp_il, input logic [31:0] exp_tg);
    dcyc(1'b1, op, r1, r2, pc, imm, 1'b1, 1'b0);
    idle(1'b1);
    chk1({tag, "_lat1"}, a_out_vld, 1'b0);
    idle(1'b1);
    chk1({tag, "_vld"}, a_out_vld, 1'b1);
    chk1({tag, "_br"}, a_branch, exp_br);
    chk1({tag, "_il"}, a_illegal, exp_il);
    chk32({tag, "_tg"}, a_target, exp_tgt_dir & exp_tg);
    idle(1'b1);
  endtask

  initial begin
    int acc;
    int ncyc;
    logic v, ordy, fl;
    logic [2:0] op;
    logic [31:0] ra, rb;
    logic [7:0] rab, rbb;
`ifdef KRONOS_BRANCH_TARGET_EN
    exp_tgt_dir = 32'hFFFF_FFFF;
`else
    exp_tgt_dir = 32'h0;
`endif
    stall_prev = 1'b0;
    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    rst = 1'b0;
    idle(1'b1);
    chk1("rst_vld", a_out_vld, 1'b0);
    chk1("rst_br", a_branch, 1'b0);
    chk1("rst_il", a_illegal, 1'b0);
    chk32("rst_tg", a_target, 32'h0);
    chk1("rst_rdy", a_in_rdy, 1'b1);

    run_one("blt", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    run_one("bltu", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_one("bge", 3'b101, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    run_one("bne_hi", 3'b001, 32'h0001_0000, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    run_one("ill010", 3'b010, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    run_one("ill011", 3'b011, 32'h5, 32'h6, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    run_one("target", 3'b000, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0010);

    // Back-to-back: four results on consecutive cycles.
    for (int k = 0; k < 7; k++) begin
      dcyc(k < 4, 3'(k + 4), 32'(k * 3), 32'(k * 5), 32'h0, 32'h0, 1'b1, 1'b0);
      if (k >= 2 && k <= 5) chk1("b2b_vld", a_out_vld, 1'b1);
      if (k == 6) chk1("b2b_end", a_out_vld, 1'b0);
    end

    // Downstream stalled: only two ops accepted, outputs held.
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      dcyc(1'b1, 3'b001, 32'(k), 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
      if (a_in_rdy) acc++;
    end
    chk32("stall_accepts", 32'(acc), 32'd2);
    repeat (3) idle(1'b1);

    // Both stages full, then flush with out_rdy=1.
    dcyc(1'b1, 3'b000, 32'h7, 32'h7, 32'h0, 32'h0, 1'b0, 1'b0);
    dcyc(1'b1, 3'b000, 32'h8, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
    dcyc(1'b1, 3'b000, 32'h9, 32'h9, 32'h0, 32'h0, 1'b1, 1'b1);
    chk1("flush_rdy", a_in_rdy, 1'b0);
    idle(1'b1);
    chk1("flush_vld", a_out_vld, 1'b0);
    idle(1'b1);
    chk1("flush_vld2", a_out_vld, 1'b0);

    // Reset mid-operation discards the in-flight op.
    dcyc(1'b1, 3'b000, 32'h3, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    idle(1'b1);
    chk1("rst_mid_vld", a_out_vld, 1'b0);
    idle(1'b1);
    chk1("rst_mid_vld2", a_out_vld, 1'b0);

    // Random scoreboard run on both configurations.
    acc  = 0;
    ncyc = 0;
    while (acc < 4096 && ncyc < 30000) begin
      v    = ($urandom_range(0, 9) < 8);
      op   = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rab  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       begin rb = ra; rbb = rab; end
        1:       begin rb = ra ^ (32'h1 << $urandom_range(0, 31)); rbb = rab ^ (8'h1 << $urandom_range(0, 7)); end
        default: begin rb = $urandom; rbb = 8'($urandom); end
      endcase
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 63) == 0);
      cyc(v, op, ra, rb, $urandom, $urandom, rab, rbb, 8'($urandom), 8'($urandom), ordy, fl);
      if (in_vld && a_in_rdy) acc++;
      ncyc++;
    end
    chk32("random_ops", 32'(acc), 32'd4096);
    repeat (4) idle(1'b1);
    chk32("drain32", 32'(q32.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
